// File: rtl/ikaopm_regwr_sched.sv
// CPU register-write scheduler: synchronizes bus writes, queues {addr,data}, commits one pair per CYCLE_31 phi1 slot then holds BUSY.
// Latency ~3 EMUCLK capture + next CYCLE_31 enable; a full queue drops data writes (sticky o_OVERRUN). IKAOPM_REGWR_FIFO_EN selects the deep queue.
module ikaopm_regwr_sched #(
  parameter int FIFO_DEPTH  = 4,
  parameter int BUSY_CYCLES = 32
) (
  input  logic       i_EMUCLK,
  input  logic       i_IC_n,
  input  logic       i_phi1_NCEN_n,
  input  logic       i_CYCLE_31,
  input  logic       i_CS_n,
  input  logic       i_WR_n,
  input  logic       i_A0,
  input  logic [7:0] i_D,
  input  logic       i_OVR_CLR,
  output logic       o_WR_STROBE,
  output logic [7:0] o_WR_ADDR,
  output logic [7:0] o_WR_DATA,
  output logic       o_BUSY,
  output logic       o_OVERRUN
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_SLOT, S_COMMIT, S_HOLD} state_t;

  // sync_q[1] is the synchronized strobe, sync_q[2] its delayed copy for edge detection
  logic [2:0] sync_q;
  logic [2:0] a0_q;
  logic [7:0] d_s1, d_s2, d_s3;
  logic       wr_evt, addr_evt, data_evt;
  logic [7:0] addr_latch;

  logic        q_empty, q_full, q_pop, q_push, q_drop;
  logic [15:0] q_head;

  state_t     state_q, state_nx;
  logic [5:0] busy_cnt_q, busy_cnt_nx;
  logic       strobe_q, strobe_nx;
  logic [7:0] wr_addr_q, wr_addr_nx;
  logic [7:0] wr_data_q, wr_data_nx;
  logic       busy_q;
  logic       overrun_q;

  always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
    if (!i_IC_n) begin
      sync_q <= 3'b111;
      a0_q   <= '0;
      d_s1   <= '0;
      d_s2   <= '0;
      d_s3   <= '0;
    end else begin
      sync_q <= {sync_q[1:0], i_CS_n | i_WR_n};
      a0_q   <= {a0_q[1:0], i_A0};
      d_s1   <= i_D;
      d_s2   <= d_s1;
      d_s3   <= d_s2;
    end
  end

  // End of a CPU write; A0/D come from the last sample taken while the write was still active
  assign wr_evt   = sync_q[1] & ~sync_q[2];
  assign addr_evt = wr_evt & ~a0_q[2];
  assign data_evt = wr_evt & a0_q[2];

  always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
    if (!i_IC_n) begin
      addr_latch <= '0;
    end else if (addr_evt) begin
      addr_latch <= d_s3;
    end
  end

  // A pop in the same cycle frees a slot, so a push onto a full queue still lands
  assign q_push = data_evt & (~q_full | q_pop);
  assign q_drop = data_evt & q_full & ~q_pop;

`ifdef IKAOPM_REGWR_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [15:0] mem [FIFO_DEPTH];
  logic [AW:0] wptr, rptr;

  assign q_empty = (wptr == rptr);
  assign q_full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign q_head  = mem[rptr[AW-1:0]];

  always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
    if (!i_IC_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (q_push) wptr <= wptr + 1'b1;
      if (q_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge i_EMUCLK) begin
    if (q_push) mem[wptr[AW-1:0]] <= {addr_latch, d_s3};
  end
`else
  logic        hold_vld;
  logic [15:0] hold_dat;
  logic [31:0] unused_depth;

  // Depth is fixed at one pair in the chip-accurate build
  assign unused_depth = FIFO_DEPTH;
  assign q_empty      = ~hold_vld;
  assign q_full       = hold_vld;
  assign q_head       = hold_dat;

  always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
    if (!i_IC_n) begin
      hold_vld <= 1'b0;
      hold_dat <= '0;
    end else if (q_push) begin
      hold_vld <= 1'b1;
      hold_dat <= {addr_latch, d_s3};
    end else if (q_pop) begin
      hold_vld <= 1'b0;
    end
  end
`endif

  always_comb begin
    state_nx    = state_q;
    busy_cnt_nx = busy_cnt_q;
    strobe_nx   = strobe_q;
    wr_addr_nx  = wr_addr_q;
    wr_data_nx  = wr_data_q;
    q_pop       = 1'b0;
    if (!i_phi1_NCEN_n) begin
      case (state_q)
        // IDLE also takes the slot directly so a pending pair never misses the first CYCLE_31
        S_IDLE, S_WAIT_SLOT: begin
          if (q_empty) begin
            state_nx = S_IDLE;
          end else if (i_CYCLE_31) begin
            q_pop      = 1'b1;
            strobe_nx  = 1'b1;
            wr_addr_nx = q_head[15:8];
            wr_data_nx = q_head[7:0];
            state_nx   = S_COMMIT;
          end else begin
            state_nx = S_WAIT_SLOT;
          end
        end
        S_COMMIT: begin
          strobe_nx   = 1'b0;
          busy_cnt_nx = 6'(BUSY_CYCLES - 1);
          state_nx    = S_HOLD;
        end
        S_HOLD: begin
          if (busy_cnt_q == 6'd0) begin
            state_nx = q_empty ? S_IDLE : S_WAIT_SLOT;
          end else begin
            busy_cnt_nx = busy_cnt_q - 6'd1;
          end
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
    if (!i_IC_n) begin
      state_q    <= S_IDLE;
      busy_cnt_q <= '0;
      strobe_q   <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_nx;
      busy_cnt_q <= busy_cnt_nx;
      strobe_q   <= strobe_nx;
      wr_addr_q  <= wr_addr_nx;
      wr_data_q  <= wr_data_nx;
    end
  end

  always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
    if (!i_IC_n) begin
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      busy_q <= ~q_empty | (state_q != S_IDLE);
      if (q_drop) begin
        overrun_q <= 1'b1;
      end else if (i_OVR_CLR) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign o_WR_STROBE = strobe_q;
  assign o_WR_ADDR   = wr_addr_q;
  assign o_WR_DATA   = wr_data_q;
  assign o_BUSY      = busy_q;
  assign o_OVERRUN   = overrun_q;

endmodule
